// File: rtl/div3_serial_ctrl_if.sv
// Operand/result handshake bundle for div3_serial_ctrl.
//   in_valid/in_ready/in_data/in_signed : operand channel (producer -> controller)
//   out_valid/out_ready/out_residue/out_div : result channel (controller -> consumer)
// master = producer/consumer side, slave = the controller.
interface div3_serial_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_residue;
  logic             out_div;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_residue, out_div
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_residue, out_div
  );
endinterface

// File: rtl/div3_serial_ctrl.sv
// Serial divisibility-by-3 checker. Accepts one WIDTH-bit operand, folds it
// MSB-first BPC bits per cycle into a mod-3 residue and returns |x| mod 3.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : operand and result handshakes (slave side)
//   abort_i    : synchronous cancel of the operation in flight
//   busy_o     : controller is in RUN or DONE
// All outputs are registered.
module div3_serial_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  div3_serial_ctrl_if.slave   bus,
  input  logic                abort_i,
  output logic                busy_o
);

  localparam int unsigned NCHUNK = WIDTH / BPC;
  localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);
  // 2^BPC mod 3: 2 for BPC=1, 1 for BPC=2 and BPC=4
  localparam logic [3:0]  PMOD   = (BPC == 1) ? 4'd2 : 4'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       res_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       out_res_q;
  logic             out_div_q;
  logic             busy_q;

  // 4-bit value reduced mod 3
  function automatic logic [1:0] mod3_4(input logic [3:0] x);
    logic [3:0] t;
    t = x % 4'd3;
    return t[1:0];
  endfunction

  logic             accept_c;
  logic [WIDTH-1:0] load_c;
  logic [BPC-1:0]   chunk_c;
  logic [3:0]       sum_c;
  logic [1:0]       res_nxt_c;

  // Operand magnitude, residue fold kept within 4 bits (max 2*2+2 = 6)
  always_comb begin
    accept_c  = bus.in_valid && in_ready_q && !abort_i && (state_q == S_IDLE);
    load_c    = (bus.in_signed && bus.in_data[WIDTH-1]) ? (~bus.in_data + WIDTH'(1))
                                                        : bus.in_data;
    chunk_c   = shift_q[WIDTH-1 -: BPC];
    sum_c     = PMOD * {2'b00, res_q} + {2'b00, mod3_4(4'(chunk_c))};
    res_nxt_c = mod3_4(sum_c);
  end

  // Controller FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      res_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_res_q   <= 2'd0;
      out_div_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else if (abort_i && (state_q != S_IDLE)) begin
      // abort wins over a same-cycle result handshake
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            shift_q    <= load_c;
            res_q      <= 2'd0;
            cnt_q      <= CNT_W'(NCHUNK);
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          shift_q <= shift_q << BPC;
          cnt_q   <= cnt_q - CNT_W'(1);
          res_q   <= res_nxt_c;
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            out_res_q   <= res_nxt_c;
            out_div_q   <= (res_nxt_c == 2'd0);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_residue = out_res_q;
  assign bus.out_div     = out_div_q;
  assign busy_o          = busy_q;

endmodule

// File: doc/div3_serial_ctrl.md
Name: div3_serial_ctrl

Overview:
- Sequential controller that checks divisibility by 3 on a stream of WIDTH-bit operands, one operand at a time.
- Takes operands over a valid/ready handshake and walks them MSB-first, BPC bits per cycle, through a mod-3 residue register.
- Returns residue and divisible flag over a second valid/ready handshake.
- Low-area, multi-cycle replacement for the flat combinational divisibility checker; sits between an operand producer and a result consumer.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of BPC.
- BPC, 2, bits consumed per RUN cycle; legal values 1, 2, 4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  controller can accept an operand.
- in_data  in  WIDTH  operand.
- in_signed  in  1  operand is two's complement; sampled with in_data.
- abort  in  1  synchronous cancel of the current operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_residue  out  2  |operand| mod 3, value 0..2.
- out_div  out  1  1 when out_residue == 0.
- busy  out  1  state is RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n=0, asynchronous): state=IDLE; in_ready=1; out_valid=0; out_residue=0; out_div=0; busy=0; shift register=0; chunk counter=0; residue register=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge, load the shift register.
    - Load value is in_data, or its two's-complement negation when in_signed=1 and in_data[WIDTH-1]=1.
    - Negation is computed modulo 2^WIDTH, so the most-negative value loads as 2^(WIDTH-1), treated as unsigned.
  - residue register := 0; counter := WIDTH/BPC; state := RUN.
- RUN:
  - in_ready=0.
  - Each cycle, take the top BPC bits of the shift register as chunk c (unsigned).
  - residue := (residue*2^BPC + c) mod 3, computed in at most 4-bit intermediate width; the register never holds 3.
  - Shift the register left by BPC; decrement the counter.
  - When the counter reaches 1 in a RUN cycle, that cycle's update is the last and state := DONE.
- Latency: out_valid rises exactly WIDTH/BPC edges after the accepting edge (16 for the defaults).
- DONE:
  - out_valid=1; out_residue = residue register; out_div = (residue==0).
  - Outputs held stable while out_valid && !out_ready.
  - On out_valid&&out_ready: state := IDLE, out_valid := 0, in_ready = 1 from the next cycle.
  - No same-cycle accept of a new operand.
  - Throughput: one operand per WIDTH/BPC+2 cycles with no stalls.
- abort:
  - In RUN or DONE: next state IDLE; out_valid := 0; the result is discarded.
  - abort has priority over the out handshake in the same cycle.
  - In IDLE: abort blocks acceptance in that cycle (in_ready stays 1 but no load occurs).
- in_data and in_signed are ignored outside the accepting edge; changes during RUN have no effect.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; no result emitted.
- busy = (state != IDLE).
- The sign only affects the magnitude taken; out_residue is always the residue of the magnitude.

Test Plan:
- Unsigned 0x00000000, then 0x00000007 -> residue 0/div 1, then residue 1/div 0; each out_valid exactly 16 cycles after its accept edge.
- Unsigned 0xFFFFFFFF -> residue 0, div 1. Same word with in_signed=1 (magnitude 1) -> residue 1, div 0.
- Signed 0xFFFFFFF9 (-7) -> residue 1, div 0. Unsigned 0xFFFFFFF9 -> residue 0, div 1. Signed 0x80000000 -> residue 2, div 0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0 throughout; release -> IDLE and in_ready=1 next cycle.
- abort on cycle 8 of RUN with operand 0x00000003 -> no out_valid. Next operand 0x00000005 -> residue 2.
- rst_n pulsed low mid-RUN -> all outputs at reset values immediately. Random sweep of 10k operands for each BPC in {1,2,4} -> matches a behavioural (|x| mod 3) model.
